// File: rtl/pcm_fifo_reader_if.sv
// FIFO-side and serial-side signals of the PCM FIFO reader, bundled for port connection.
// master = the reader itself, slave = the FIFO / serial consumer side.
interface pcm_fifo_reader_if #(
   parameter int DBITS = 16
);
   logic             enable;
   logic             empty;
   logic             rd;
   logic [DBITS-1:0] din;
   logic             sdata;
   logic             sclk;
   logic             frame;
   logic             busy;
   logic [7:0]       underruns;

   modport master (
      input  enable, empty, din,
      output rd, sdata, sclk, frame, busy, underruns
   );

   modport slave (
      output enable, empty, din,
      input  rd, sdata, sclk, frame, busy, underruns
   );
endinterface

// File: rtl/pcm_fifo_reader.sv
// Fetches words from a FIFO and shifts them out MSB first as serial PCM with bit/frame strobes.
// Optional underrun counter: define PCM_FIFO_READER_UNDERRUN_EN.
module pcm_fifo_reader #(
   parameter int DBITS   = 16,
   parameter int BIT_DIV = 4
) (
   input  logic                clock,
   input  logic                reset,
   pcm_fifo_reader_if.master   bus
);

   localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;
   localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_LOAD  = 3'd3,
      S_SHIFT = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [DBITS-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]    div_cnt_q, div_cnt_d;
   logic [1:0]       wait_cnt_q, wait_cnt_d;
   logic             hold_q, hold_d;
   logic             rd_q, rd_d;
   logic             sdata_q, sdata_d;
   logic             sclk_q, sclk_d;
   logic             frame_q, frame_d;
   logic             busy_q, busy_d;
   logic             fetch_ok_s;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      div_cnt_d  = div_cnt_q;
      wait_cnt_d = wait_cnt_q;
      hold_d     = 1'b0;
      fetch_ok_s = bus.enable & ~bus.empty;

      case (state_q)
         S_IDLE: begin
            // hold_q keeps the first post-reset cycle quiet so no rd follows reset directly
            if (fetch_ok_s && !hold_q) begin
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            wait_cnt_d = 2'd0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt_q == 2'd2) begin
               state_d = S_LOAD;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end
         S_LOAD: begin
            shreg_d    = bus.din;
            bit_cnt_d  = '0;
            div_cnt_d  = '0;
            wait_cnt_d = 2'd0;
            state_d    = S_SHIFT;
         end
         S_SHIFT: begin
            if (div_cnt_q == DW'(BIT_DIV - 1)) begin
               div_cnt_d = '0;
               shreg_d   = {shreg_q[DBITS-2:0], 1'b0};
               if (bit_cnt_q == BW'(DBITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = fetch_ok_s ? S_REQ : S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               div_cnt_d = div_cnt_q + DW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they line up with the state they describe.
      rd_d    = (state_d == S_REQ);
      frame_d = (state_d == S_LOAD);
      busy_d  = (state_d != S_IDLE);
      sclk_d  = (state_d == S_SHIFT) && (div_cnt_d == '0);
      sdata_d = (state_d == S_SHIFT) ? shreg_d[DBITS-1] : 1'b0;
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         div_cnt_q  <= '0;
         wait_cnt_q <= 2'd0;
         hold_q     <= 1'b1;
         rd_q       <= 1'b0;
         sdata_q    <= 1'b0;
         sclk_q     <= 1'b0;
         frame_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         div_cnt_q  <= div_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         hold_q     <= hold_d;
         rd_q       <= rd_d;
         sdata_q    <= sdata_d;
         sclk_q     <= sclk_d;
         frame_q    <= frame_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.rd    = rd_q;
   assign bus.sdata = sdata_q;
   assign bus.sclk  = sclk_q;
   assign bus.frame = frame_q;
   assign bus.busy  = busy_q;

`ifdef PCM_FIFO_READER_UNDERRUN_EN
   logic [7:0] underruns_q, underruns_d;
   logic       underrun_s;

   // Underrun: last cycle of the last bit while enabled with nothing left to fetch.
   always_comb begin
      underrun_s = (state_q == S_SHIFT) && (div_cnt_q == DW'(BIT_DIV - 1)) &&
                   (bit_cnt_q == BW'(DBITS - 1)) && bus.enable && bus.empty;
      if (underrun_s && (underruns_q != 8'hFF)) begin
         underruns_d = underruns_q + 8'd1;
      end else begin
         underruns_d = underruns_q;
      end
   end

   // Saturating underrun event counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         underruns_q <= 8'd0;
      end else begin
         underruns_q <= underruns_d;
      end
   end

   assign bus.underruns = underruns_q;
`else
   assign bus.underruns = 8'd0;
`endif

endmodule

// File: doc/pcm_fifo_reader.md
PCM_FIFO_READER -- requirements
Module: pcm_fifo_reader

Interface
REQ-001 Parameter DBITS, default 16: sample word width in bits (legal range 2..512).
REQ-002 Parameter BIT_DIV, default 4: clock cycles per serial bit (minimum 2).
REQ-003 Port clock, input, 1: single clock; all logic is on the rising edge.
REQ-004 Port reset, input, 1: synchronous reset, active-low; the only reset.
REQ-005 Port enable, input, 1: high permits fetching new words from the FIFO.
REQ-006 Port empty, input, 1: FIFO empty flag.
REQ-007 Port rd, output, 1: FIFO read request, a single-cycle high pulse (the FIFO acts on the falling edge).
REQ-008 Port din, input, DBITS: FIFO data out.
REQ-009 Port sdata, output, 1: serial PCM data, MSB first.
REQ-010 Port sclk, output, 1: one-cycle strobe at the first cycle of each serial bit.
REQ-011 Port frame, output, 1: one-cycle strobe when a new word is loaded.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port underruns, output, 8: underrun event count (see Configuration).

Function
REQ-014 The block SHALL implement the FSM states IDLE, REQ, WAIT, LOAD and SHIFT.
REQ-015 IDLE: if enable=1 and empty=0, go to REQ; otherwise stay in IDLE.
REQ-016 REQ: drive rd=1 for exactly one cycle, then go to WAIT; rd=0 in every other state.
REQ-017 WAIT: hold for exactly 3 cycles, then go to LOAD; this covers the FIFO edge detector plus registered output latency.
REQ-018 LOAD: capture din into the DBITS shift register, assert frame=1 for that cycle, clear the bit and divider counters, then go to SHIFT.
REQ-019 With rd high in cycle T, LOAD SHALL occur in cycle T+4 and sample din in that cycle.
REQ-020 SHIFT: sdata = shift register MSB, held for BIT_DIV cycles per bit.
- sclk=1 in the first cycle of each bit.
- The register shifts left with zero fill after BIT_DIV cycles.
- The first bit starts in cycle LOAD+1.
REQ-021 After DBITS bits (DBITS*BIT_DIV cycles in SHIFT):
- enable=1 and empty=0: go directly to REQ (back-to-back words).
- Otherwise: go to IDLE.
REQ-022 Deasserting enable during REQ, WAIT, LOAD or SHIFT SHALL NOT abort the current word; it only blocks the next fetch.
REQ-023 sdata SHALL be 0 in IDLE, REQ, WAIT and LOAD.
REQ-024 An underrun event is defined as the end of a word with enable=1 and empty=1; exactly one event is counted per such word end.
REQ-025 An empty flag that rises during WAIT SHALL be ignored; the word already requested is still loaded and shifted.

Reset
REQ-026 When reset=0 at a rising edge, the block SHALL enter IDLE.
REQ-027 Reset values: rd=0, sdata=0, sclk=0, frame=0, busy=0, underruns=0; shift register and all counters = 0.
REQ-028 A reset during any state, including mid-word, SHALL abandon the word immediately, with no rd pulse in the reset cycle or the following cycle.

Configuration
REQ-029 Macro PCM_FIFO_READER_UNDERRUN_EN controls the underrun counter.
- Defined: underruns is an 8-bit counter incremented on each underrun event and saturating at 255.
- Undefined: underruns is constant 0 and no counter logic is synthesized.
- All other behaviour is identical in both builds.

Verification
REQ-030 Single word: DBITS=16, BIT_DIV=4, din=16'hA5C3, empty falls, enable=1.
- Expect one rd pulse, frame 4 cycles later, then sdata bits 1010010111000011.
- Expect 16 sclk strobes, 4 cycles apart, then busy=0.
REQ-031 Back-to-back: FIFO holds 3 words, enable=1.
- Expect 3 rd pulses, each issued the cycle after the previous word's final bit period.
- No IDLE cycles between words.
REQ-032 Enable drop: deassert enable at bit 5 of a word.
- The word completes all 16 bits.
- No further rd pulse follows.
REQ-033 Underrun (macro defined): one word, empty=1 afterwards, enable held high.
- underruns=1 after the word.
- After 300 forced underrun events, underruns=255.
- Macro undefined: underruns stays 0.
REQ-034 Reset mid-SHIFT: assert reset=0 for 1 cycle at bit 8.
- Next cycle: all outputs at reset values and state IDLE.
- Operation resumes cleanly on the next non-empty FIFO.
